// File: rtl/zbt_frame_arbiter.sv
// Sole owner of the ZBT SRAM port: arbitrates VGA reads against NTSC writes and
// double-buffers frames so NTSC fills the back buffer while VGA shows the front one.
module zbt_frame_arbiter #(
    parameter int DATA_W    = 36,
    parameter int ADDR_W    = 19,
    parameter int BUF1_BASE = 153600
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_flag,
    input  logic [9:0]        vga_hcount,
    input  logic [9:0]        vga_vcount,
    output logic [DATA_W-1:0] vga_pixel,
    output logic              done_vga,
    input  logic              ntsc_flag,
    input  logic [9:0]        ntsc_hcount,
    input  logic [9:0]        ntsc_vcount,
    input  logic [DATA_W-1:0] ntsc_pixel,
    output logic              done_ntsc,
    input  logic              frame_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    output logic              display_buf,
    output logic              ntsc_overflow
);

    function automatic logic [ADDR_W-1:0] frame_addr(input logic sel, input logic [9:0] v,
                                                     input logic [9:0] h);
        logic [ADDR_W-1:0] vv;
        vv = ADDR_W'(v);
        return (sel ? ADDR_W'(BUF1_BASE) : '0) + (vv << 8) + (vv << 6) + ADDR_W'(h[9:1]);
    endfunction

    logic              swap_pending;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic [2:0]        rd_valid;
    logic [1:0]        wr_valid;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;

    logic              do_swap;
    logic              front_buf;
    logic              write_issue;
    logic [ADDR_W-1:0] vga_addr;
    logic [ADDR_W-1:0] ntsc_addr;
    logic              unused_lsb;

    // The swap takes effect in the same cycle as the first fetch of the frame,
    // so that fetch and any coincident NTSC request already see the new buffers.
    always_comb begin
        do_swap     = vga_flag && swap_pending && (vga_vcount == '0) && (vga_hcount[9:1] == '0);
        front_buf   = display_buf ^ do_swap;
        vga_addr    = frame_addr(front_buf, vga_vcount, vga_hcount);
        ntsc_addr   = frame_addr(!front_buf, ntsc_vcount, ntsc_hcount);
        write_issue = !vga_flag && (pend_valid || ntsc_flag);
        unused_lsb  = vga_hcount[0] ^ ntsc_hcount[0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vga_pixel     <= '0;
            done_vga      <= 1'b0;
            done_ntsc     <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_dout      <= '0;
            display_buf   <= 1'b0;
            ntsc_overflow <= 1'b0;
            swap_pending  <= 1'b0;
            pend_valid    <= 1'b0;
            pend_addr     <= '0;
            pend_data     <= '0;
            rd_valid      <= '0;
            wr_valid      <= '0;
            wr_data0      <= '0;
            wr_data1      <= '0;
        end else begin
            mem_we       <= 1'b0;
            done_ntsc    <= 1'b0;
            done_vga     <= rd_valid[2];
            rd_valid     <= {rd_valid[1:0], vga_flag};
            wr_valid     <= {wr_valid[0], write_issue};
            wr_data1     <= wr_data0;
            display_buf  <= front_buf;
            swap_pending <= do_swap ? 1'b0 : (swap_pending | frame_flag);
            if (rd_valid[2]) vga_pixel <= mem_din;
            if (wr_valid[1]) mem_dout <= wr_data1;

            if (vga_flag) begin
                mem_addr <= vga_addr;
                if (ntsc_flag) begin
                    if (pend_valid) begin
                        ntsc_overflow <= 1'b1;
                    end else begin
                        pend_valid <= 1'b1;
                        pend_addr  <= ntsc_addr;
                        pend_data  <= ntsc_pixel;
                    end
                end
            end else if (pend_valid) begin
                mem_addr   <= pend_addr;
                mem_we     <= 1'b1;
                done_ntsc  <= 1'b1;
                wr_data0   <= pend_data;
                pend_valid <= 1'b0;
                if (ntsc_flag) ntsc_overflow <= 1'b1;
            end else if (ntsc_flag) begin
                mem_addr  <= ntsc_addr;
                mem_we    <= 1'b1;
                done_ntsc <= 1'b1;
                wr_data0  <= ntsc_pixel;
            end
        end
    end

endmodule

// File: tb/tb_zbt_frame_arbiter.sv
// Directed + randomised bench for zbt_frame_arbiter with a scoreboard of expected
// SRAM issues, write data and returned pixels, plus a behavioural SRAM read path.
module tb_zbt_frame_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        vga_flag;
    logic [9:0]  vga_hcount, vga_vcount;
    logic [35:0] vga_pixel;
    logic        done_vga;
    logic        ntsc_flag;
    logic [9:0]  ntsc_hcount, ntsc_vcount;
    logic [35:0] ntsc_pixel;
    logic        done_ntsc;
    logic        frame_flag;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_dout;
    logic [35:0] mem_din;
    logic        display_buf;
    logic        ntsc_overflow;

    zbt_frame_arbiter #(.DATA_W(36), .ADDR_W(19), .BUF1_BASE(153600)) dut (
        .clock(clock), .reset(reset),
        .vga_flag(vga_flag), .vga_hcount(vga_hcount), .vga_vcount(vga_vcount),
        .vga_pixel(vga_pixel), .done_vga(done_vga),
        .ntsc_flag(ntsc_flag), .ntsc_hcount(ntsc_hcount), .ntsc_vcount(ntsc_vcount),
        .ntsc_pixel(ntsc_pixel), .done_ntsc(done_ntsc), .frame_flag(frame_flag),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout), .mem_din(mem_din),
        .display_buf(display_buf), .ntsc_overflow(ntsc_overflow)
    );

    always #5 clock = ~clock;

    typedef struct { int cyc; logic we; logic [18:0] addr; } iss_t;
    typedef struct { int cyc; logic [35:0] d; } dat_t;

    iss_t iss_q[$];
    dat_t dout_q[$];
    dat_t pix_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference state
    logic        m_buf, m_swap, m_pend, m_ovf;
    logic [18:0] m_pend_addr;
    logic [35:0] m_pend_data;
    logic [18:0] hist1, hist2;

    function automatic logic [35:0] pat(input logic [18:0] a);
        return (36'(a) * 36'd7919) ^ 36'hABCDE;
    endfunction

    function automatic logic [18:0] ref_addr(input logic sel, input int v, input int h);
        int base;
        base = sel ? 153600 : 0;
        return 19'(base + v * 320 + h / 2);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        iss_t e;
        dat_t d;
        logic exp_we, exp_dv;
        @(posedge clock);
        #1;
        cyc++;
        mem_din = pat(hist2);
        hist2 = hist1;
        hist1 = mem_addr;
        exp_we = 1'b0;
        exp_dv = 1'b0;
        if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
            e = iss_q.pop_front();
            exp_we = e.we;
            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        end
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("done_ntsc", 64'(done_ntsc), 64'(exp_we));
        if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
            d = pix_q.pop_front();
            exp_dv = 1'b1;
            chk("vga_pixel", 64'(vga_pixel), 64'(d.d));
        end
        chk("done_vga", 64'(done_vga), 64'(exp_dv));
        if (dout_q.size() > 0 && dout_q[0].cyc == cyc) begin
            d = dout_q.pop_front();
            chk("mem_dout", 64'(mem_dout), 64'(d.d));
        end
        chk("display_buf", 64'(display_buf), 64'(m_buf));
        chk("ntsc_overflow", 64'(ntsc_overflow), 64'(m_ovf));
    endtask

    task automatic drive(input logic vf, input int vh, input int vv, input logic nf, input int nh,
                         input int nv, input logic [35:0] np, input logic ff);
        logic sw;
        logic [18:0] va, na;
        vga_flag = vf; vga_hcount = 10'(vh); vga_vcount = 10'(vv);
        ntsc_flag = nf; ntsc_hcount = 10'(nh); ntsc_vcount = 10'(nv); ntsc_pixel = np;
        frame_flag = ff;
        sw = vf && m_swap && vv == 0 && vh < 2;
        if (sw) m_buf = ~m_buf;
        m_swap = sw ? 1'b0 : (m_swap | ff);
        va = ref_addr(m_buf, vv, vh);
        na = ref_addr(~m_buf, nv, nh);
        if (vf) begin
            iss_q.push_back('{cyc + 1, 1'b0, va});
            pix_q.push_back('{cyc + 4, pat(va)});
            if (nf) begin
                if (m_pend) m_ovf = 1'b1;
                else begin
                    m_pend = 1'b1; m_pend_addr = na; m_pend_data = np;
                end
            end
        end else if (m_pend) begin
            iss_q.push_back('{cyc + 1, 1'b1, m_pend_addr});
            dout_q.push_back('{cyc + 3, m_pend_data});
            m_pend = 1'b0;
            if (nf) m_ovf = 1'b1;
        end else if (nf) begin
            iss_q.push_back('{cyc + 1, 1'b1, na});
            dout_q.push_back('{cyc + 3, np});
        end
        tick();
        vga_flag = 1'b0; ntsc_flag = 1'b0; frame_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vga_flag = 1'b0; ntsc_flag = 1'b0; frame_flag = 1'b0;
        iss_q.delete(); dout_q.delete(); pix_q.delete();
        m_buf = 1'b0; m_swap = 1'b0; m_pend = 1'b0; m_ovf = 1'b0;
        tick();
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_dout", 64'(mem_dout), 64'd0);
        chk("rst_vga_pixel", 64'(vga_pixel), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; vga_flag = 1'b0; ntsc_flag = 1'b0; frame_flag = 1'b0;
        vga_hcount = '0; vga_vcount = '0; ntsc_hcount = '0; ntsc_vcount = '0;
        ntsc_pixel = '0; mem_din = '0; hist1 = '0; hist2 = '0;
        do_reset();
        idle(2);

        // single VGA fetch: h=2, v=1 -> word 321
        drive(1'b1, 2, 1, 1'b0, 0, 0, '0, 1'b0);
        chk("t1_addr_321", 64'(mem_addr), 64'd321);
        idle(5);

        // lone NTSC write lands in back buffer 1
        drive(1'b0, 0, 0, 1'b1, 0, 0, 36'h12345, 1'b0);
        chk("t2_addr_153600", 64'(mem_addr), 64'd153600);
        idle(4);

        // simultaneous requests: read first, write one cycle later
        drive(1'b1, 10, 5, 1'b1, 4, 7, 36'h0DEAD_BEEF, 1'b0);
        idle(6);

        // second NTSC request while one is pending is dropped
        drive(1'b1, 20, 3, 1'b1, 6, 9, 36'h111111111, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 8, 9, 36'h222222222, 1'b0);
        idle(3);
        chk("t4_ovf_sticky", 64'(ntsc_overflow), 64'd1);
        idle(2);

        // frame swap at first fetch of the next frame
        drive(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b1);
        drive(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b1);
        idle(2);
        drive(1'b1, 1, 0, 1'b0, 0, 0, '0, 1'b0);
        chk("t5_swap_addr", 64'(mem_addr), 64'd153600);
        chk("t5_display_buf", 64'(display_buf), 64'd1);
        idle(4);
        drive(1'b0, 0, 0, 1'b1, 2, 0, 36'hCAFE, 1'b0);
        chk("t5_ntsc_base0", 64'(mem_addr), 64'd1);
        idle(4);

        // frame_flag coincident with first fetch defers swap by one frame
        drive(1'b1, 0, 0, 1'b0, 0, 0, '0, 1'b1);
        idle(4);
        drive(1'b1, 0, 0, 1'b0, 0, 0, '0, 1'b0);
        chk("t5_deferred_swap", 64'(display_buf), 64'd0);
        idle(5);

        // randomised traffic with VGA fetches spaced four cycles apart
        for (int i = 0; i < 80; i++) begin
            logic vf, nf, ff;
            int vv, vh;
            vf = (i % 4 == 0);
            nf = ($urandom_range(0, 2) == 0);
            ff = ($urandom_range(0, 15) == 0);
            vv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 479));
            vh = (vv == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 639));
            drive(vf, vh, vv, nf, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                  {$urandom, 4'($urandom)}, ff);
        end
        idle(6);

        // reset two cycles after a fetch kills the in-flight read
        drive(1'b1, 4, 4, 1'b0, 0, 0, '0, 1'b0);
        idle(1);
        do_reset();
        chk("t6_done_vga", 64'(done_vga), 64'd0);
        chk("t6_display_buf", 64'(display_buf), 64'd0);
        idle(4);

        chk("drain_iss", 64'(iss_q.size()), 64'd0);
        chk("drain_dout", 64'(dout_q.size()), 64'd0);
        chk("drain_pix", 64'(pix_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
